uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  UART transmitter; pairs with the team's oversampling UART receiver on the same serial link.
//  Serialises a parallel word: start bit, D_BITS data bits LSB first, optional parity, stop bit(s).
//  Paced by the shared baud-rate tick generator (S_TICKS ticks per bit).
//  A one-deep holding register lets the next word queue during a frame, so frames run back-to-back.
// PARAMETERS
//  D_BITS     8   data bits per frame (5..9)
//  S_TICKS    16  ticks per start/data/parity bit (matches the receiver's oversampling rate)
//  SB_TICKS   16  ticks for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
//  PARITY_EN  0   1: insert a parity bit after the data bits
//  PARITY_ODD 0   0: even parity, 1: odd parity (ignored when PARITY_EN=0)
// PORTS
//  clk       in   1       system clock
//  reset_n   in   1       asynchronous reset, active-low
//  tick      in   1       baud tick, one clk wide, S_TICKS per bit period
//  tx_start  in   1       request: din is valid this cycle
//  din       in   D_BITS  word to send; sampled when tx_start && in_ready
//  in_ready  out  1       holding register empty; a request is accepted this cycle
//  tx        out  1       serial line, idle high; driven from a register
//  tx_busy   out  1       frame in progress (state != IDLE)
//  tx_done   out  1       one-clk pulse at the end of each frame's stop period
// BEHAVIOUR
//  Reset (asynchronous): tx=1, in_ready=1, tx_busy=0, tx_done=0, state=IDLE, counters=0, hold empty.
//  Handshake: in_ready = !hold_valid (registered). On tx_start && in_ready, load din into hold and set hold_valid.
//   tx_start while !in_ready: ignored; the word is dropped and there is no error flag.
//  FSM states: IDLE, START, DATA, PARITY, STOP. Tick counter s and bit counter n.
//   IDLE: if hold_valid, load shift register from hold, clear hold_valid, s=0, go to START, tx<=0.
//    The first tx low occurs one clk after the accept edge.
//   START: tx=0. On each tick s++; on the tick where s==S_TICKS-1: s=0, n=0, go to DATA, tx<=shift[0].
//   DATA: tx=shift[0]. On the tick where s==S_TICKS-1: s=0 and shift>>1.
//    If n==D_BITS-1: go to PARITY if PARITY_EN (tx<=parity), otherwise go to STOP (tx<=1).
//    Otherwise n++.
//   PARITY: tx = (^data) ^ PARITY_ODD, computed from the word at load time. After S_TICKS ticks: go to STOP, tx<=1.
//   STOP: tx=1. On the tick where s==SB_TICKS-1: pulse tx_done; s=0.
//    If hold_valid: load the next word and go directly to START (tx<=0, no idle gap).
//    Otherwise go to IDLE.
//  Without a tick, state and counters hold. Ticks are counted only while in a non-IDLE state.
//  Widths: s is clog2(max(S_TICKS,SB_TICKS)) bits; n is clog2(D_BITS) bits. Neither counter wraps past its terminal value.
//  Frame length in ticks: S_TICKS*(1+D_BITS+PARITY_EN) + SB_TICKS.
//  Same-cycle events:
//   A request accepted while STOP ends with an empty hold is queued in hold.
//    The FSM reaches IDLE, then starts the frame one clk later.
//   Hold is loaded and drained on different edges; in_ready only rises the clk after the drain.
//  Reset mid-frame: tx returns to 1 immediately (async), the queued word is lost, and no tx_done is issued.
//  tx is glitch-free: it changes only on clk edges.
// TESTING
//  T1: defaults, tick every 4 clk, send 0x55 -> tx=0 for 16 ticks, then bits 1,0,1,0,1,0,1,0 each 16 ticks, then 1 for 16 ticks; tx_done once after 160 ticks.
//  T2: send 0xA5, then 0x3C while busy -> in_ready drops then recovers; the second start bit follows the first stop bit with zero gap; tx_done pulses twice.
//  T3: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1; with PARITY_ODD=1 -> 0; frame length 176 ticks.
//  T4: SB_TICKS=32, send 0xFF -> stop high for 32 ticks before tx_done; tx_busy falls on the same edge.
//  T5: two tx_start pulses while a frame is active and hold is full -> the third word is dropped; only two frames appear on tx.
//  T6: assert reset_n=0 during data bit 3 -> tx=1, in_ready=1, tx_busy=0 immediately; the next frame after release is sent intact.
//  T7: loop tx into the UART receiver, send 0x00, 0xFF and 0xC3 -> receiver dataout matches each word, with one RX_done per frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter with a one-word holding register: start bit, LSB-first data, optional parity, stop period.
// The first start bit leaves one clk after the accept. While the holding register is full, requests are dropped.
module uart_tx #(
   parameter int D_BITS     = 8,
   parameter int S_TICKS    = 16,
   parameter int SB_TICKS   = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tick,
   input  logic              tx_start,
   input  logic [D_BITS-1:0] din,
   output logic              in_ready,
   output logic              tx,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int MAX_T = (S_TICKS > SB_TICKS) ? S_TICKS : SB_TICKS;
   localparam int SW    = $clog2(MAX_T);
   localparam int NW    = $clog2(D_BITS);

   localparam logic [SW-1:0] S_LAST  = SW'(S_TICKS - 1);
   localparam logic [SW-1:0] SB_LAST = SW'(SB_TICKS - 1);
   localparam logic [NW-1:0] N_LAST  = NW'(D_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state, state_nx;
   logic [SW-1:0]     s, s_nx;
   logic [NW-1:0]     n, n_nx;
   logic [D_BITS-1:0] shift, shift_nx;
   logic              par, par_nx;
   logic              tx_nx;
   logic              done_nx;
   logic [D_BITS-1:0] hold;
   logic              hold_valid;
   logic              drain;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         s          <= '0;
         n          <= '0;
         shift      <= '0;
         par        <= 1'b0;
         tx         <= 1'b1;
         tx_done    <= 1'b0;
         hold       <= '0;
         hold_valid <= 1'b0;
      end else begin
         state   <= state_nx;
         s       <= s_nx;
         n       <= n_nx;
         shift   <= shift_nx;
         par     <= par_nx;
         tx      <= tx_nx;
         tx_done <= done_nx;
         // Accept needs an empty hold and drain needs a full one, so they never coincide.
         if (tx_start && !hold_valid) begin
            hold       <= din;
            hold_valid <= 1'b1;
         end else if (drain) begin
            hold_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nx = state;
      s_nx     = s;
      n_nx     = n;
      shift_nx = shift;
      par_nx   = par;
      tx_nx    = tx;
      done_nx  = 1'b0;
      drain    = 1'b0;
      case (state)
         IDLE: begin
            if (hold_valid) begin
               drain    = 1'b1;
               shift_nx = hold;
               par_nx   = (^hold) ^ (PARITY_ODD != 0);
               s_nx     = '0;
               state_nx = START;
               tx_nx    = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               if (s == S_LAST) begin
                  s_nx     = '0;
                  n_nx     = '0;
                  state_nx = DATA;
                  tx_nx    = shift[0];
               end else begin
                  s_nx = s + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s == S_LAST) begin
                  s_nx     = '0;
                  shift_nx = shift >> 1;
                  if (n == N_LAST) begin
                     if (PARITY_EN != 0) begin
                        state_nx = PARITY;
                        tx_nx    = par;
                     end else begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                     end
                  end else begin
                     n_nx  = n + 1'b1;
                     tx_nx = shift[1];
                  end
               end else begin
                  s_nx = s + 1'b1;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               if (s == S_LAST) begin
                  s_nx     = '0;
                  state_nx = STOP;
                  tx_nx    = 1'b1;
               end else begin
                  s_nx = s + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s == SB_LAST) begin
                  done_nx = 1'b1;
                  s_nx    = '0;
                  // A queued word starts straight away so frames run with no idle gap.
                  if (hold_valid) begin
                     drain    = 1'b1;
                     shift_nx = hold;
                     par_nx   = (^hold) ^ (PARITY_ODD != 0);
                     state_nx = START;
                     tx_nx    = 1'b0;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  s_nx = s + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign in_ready = ~hold_valid;
   assign tx_busy  = (state != IDLE);

endmodule
